// File: rtl/fft_frame_sched_if.sv
// Handshake and bus bundle between fft_frame_sched and its environment.
// slave: the scheduler itself; master: sample source, fft_core slave port and output-monitor taps.
interface fft_frame_sched_if #(
  parameter int DWIDTH = 32
);
  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [10:0]       i_cfg_point;
  logic              i_cfg_inverse;
  logic [7:0]        i_cfg_frames;
  logic [DWIDTH-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [10:0]       o_fft_point;
  logic              o_fft_inverse;
  logic [DWIDTH-1:0] m_fft_tdata;
  logic              m_fft_tvalid;
  logic              i_fft_tready;
  logic              m_fft_tlast;
  logic              i_out_tvalid;
  logic              i_out_tready;
  logic              i_out_tlast;
  logic              o_busy;
  logic              o_err_cfg;
  logic              o_err_len;

  modport slave (
    input  i_cfg_valid, i_cfg_point, i_cfg_inverse, i_cfg_frames,
    input  s_axis_tdata, s_axis_tvalid, i_fft_tready,
    input  i_out_tvalid, i_out_tready, i_out_tlast,
    output o_cfg_ready, s_axis_tready, o_fft_point, o_fft_inverse,
    output m_fft_tdata, m_fft_tvalid, m_fft_tlast,
    output o_busy, o_err_cfg, o_err_len
  );

  modport master (
    output i_cfg_valid, i_cfg_point, i_cfg_inverse, i_cfg_frames,
    output s_axis_tdata, s_axis_tvalid, i_fft_tready,
    output i_out_tvalid, i_out_tready, i_out_tlast,
    input  o_cfg_ready, s_axis_tready, o_fft_point, o_fft_inverse,
    input  m_fft_tdata, m_fft_tvalid, m_fft_tlast,
    input  o_busy, o_err_cfg, o_err_len
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame scheduler ahead of fft_core: zero-latency sample gating, tlast every point beats, in-flight frame limit.
// Source stalls on core tready or while MAX_INFLIGHT frames are outstanding; FFT_SCHED_STATS_EN adds stats counters.
module fft_frame_sched #(
  parameter int DWIDTH       = 32,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              aclk,
  input  logic              areset_n,
  fft_frame_sched_if.slave  bus
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [31:0]       o_frames_done,
  output logic [31:0]       o_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);

  state_t      state;
  logic [10:0] point;
  logic        inverse;
  logic [8:0]  frames_left;
  logic [10:0] in_cnt;
  logic [10:0] out_cnt;
  logic [2:0]  inflight;
  logic        err_cfg;
  logic        err_len;

  logic              point_legal;
  logic              streaming;
  logic              gate;
  logic              m_vld;
  logic              in_hs;
  logic              in_last;
  logic              in_done;
  logic              cfg_rdy;
  logic              cfg_hs;
  logic              out_hs;
  logic              out_at_end;
  logic              out_done;
  logic              len_bad;
  logic              dec;
  logic [DWIDTH-1:0] pass_dat;

  assign point_legal = bus.i_cfg_point inside {11'd16, 11'd32, 11'd64, 11'd128,
                                               11'd256, 11'd512, 11'd1024};
  assign streaming   = (state == STREAM);
  // Inflight only rises on a tlast beat, so the gate can only close between frames.
  assign gate        = (inflight < MAX_IF);
  assign m_vld       = streaming & bus.s_axis_tvalid & gate;
  assign in_last     = (in_cnt == point - 11'd1);
  assign in_hs       = m_vld & bus.i_fft_tready;
  assign in_done     = in_hs & in_last;
  assign cfg_rdy     = (state == IDLE) && (inflight == 3'd0);
  assign cfg_hs      = bus.i_cfg_valid & cfg_rdy;

  assign out_hs      = bus.i_out_tvalid & bus.i_out_tready;
  assign out_at_end  = (out_cnt == point - 11'd1);
  assign out_done    = out_hs & (bus.i_out_tlast | out_at_end);
  assign len_bad     = out_hs & ((bus.i_out_tlast ^ out_at_end) |
                                 (bus.i_out_tlast & (inflight == 3'd0)));
  assign dec         = out_done & (inflight != 3'd0);

  assign pass_dat          = bus.s_axis_tdata;
  assign bus.m_fft_tdata   = pass_dat;
  assign bus.m_fft_tvalid  = m_vld;
  assign bus.m_fft_tlast   = in_last;
  assign bus.s_axis_tready = streaming & bus.i_fft_tready & gate;
  assign bus.o_cfg_ready   = cfg_rdy;
  assign bus.o_fft_point   = point;
  assign bus.o_fft_inverse = inverse;
  assign bus.o_busy        = (state != IDLE) || (inflight != 3'd0);
  assign bus.o_err_cfg     = err_cfg;
  assign bus.o_err_len     = err_len;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      point       <= 11'd1024;
      inverse     <= 1'b0;
      frames_left <= 9'd0;
      in_cnt      <= 11'd0;
      out_cnt     <= 11'd0;
      inflight    <= 3'd0;
      err_cfg     <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      err_cfg <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_hs) begin
            if (point_legal) begin
              point       <= bus.i_cfg_point;
              inverse     <= bus.i_cfg_inverse;
              frames_left <= (bus.i_cfg_frames == 8'd0) ? 9'd256 : {1'b0, bus.i_cfg_frames};
              state       <= STREAM;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (in_done) begin
            frames_left <= frames_left - 9'd1;
            if (frames_left == 9'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == 3'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (in_hs) in_cnt <= in_last ? 11'd0 : in_cnt + 11'd1;
      if (out_hs) out_cnt <= out_done ? 11'd0 : out_cnt + 11'd1;
      inflight <= inflight + {2'b00, in_done} - {2'b00, dec};

      // A length fault in the same cycle as a new job still sticks.
      if (len_bad) err_len <= 1'b1;
      else if (cfg_hs && point_legal) err_len <= 1'b0;
    end
  end

`ifdef FFT_SCHED_STATS_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      o_frames_done  <= 32'd0;
      o_stall_cycles <= 32'd0;
    end else begin
      if (out_hs && bus.i_out_tlast) o_frames_done <= o_frames_done + 32'd1;
      if (streaming && bus.s_axis_tvalid && !gate) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: count-based job model checked every cycle, a simple fft_core
// stand-in that returns one output frame per input frame, plus literal checks per scenario.
module tb_fft_frame_sched;
  localparam int DW   = 32;
  localparam int MAXI = 2;

  logic aclk     = 1'b0;
  logic areset_n = 1'b0;

  fft_frame_sched_if #(.DWIDTH(DW)) bus();

`ifdef FFT_SCHED_STATS_EN
  logic [31:0] frames_done;
  logic [31:0] stall_cycles;
`endif

  fft_frame_sched #(.DWIDTH(DW), .MAX_INFLIGHT(MAXI)) dut (
    .aclk(aclk),
    .areset_n(areset_n),
    .bus(bus)
`ifdef FFT_SCHED_STATS_EN
    ,
    .o_frames_done(frames_done),
    .o_stall_cycles(stall_cycles)
`endif
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus controls and core stand-in state
  bit          src_en = 0, core_rdy = 0, out_en = 0, out_rdy = 0;
  int          inj_at = -1;
  logic [31:0] src_dat = 32'h1000_0001;
  int          core_pending = 0, core_beat = 0;
  bit          ev_src_hs = 0, ev_in_tlast = 0, ev_out_hs = 0, ev_out_last = 0;

  // Observed counters for literal checks
  int acc_beats = 0, tl_count = 0, tl_first = -1, tl_lastidx = -1, simul_cnt = 0;

  // Behavioural job model
  bit m_active, m_err_cfg, m_err_len, m_inv;
  int m_point, m_nframes, m_fed, m_in_beats, m_inflight, m_out_beats;
  bit e_stream, e_g, e_mvalid, e_sready, e_tlast, e_cfg_ready, e_busy;
  bit x_in_hs, x_in_fin, x_out_hs, x_out_end, x_bad, x_cfg_hs, x_legal;

  task automatic model_reset();
    m_active = 0; m_err_cfg = 0; m_err_len = 0; m_inv = 0;
    m_point = 1024; m_nframes = 0; m_fed = 0; m_in_beats = 0;
    m_inflight = 0; m_out_beats = 0;
  endtask

  initial model_reset();

  // Source and core stand-in drive inputs just after each rising edge.
  always @(posedge aclk) begin
    #1;
    if (!areset_n) begin
      core_pending = 0;
      core_beat    = 0;
    end else begin
      if (ev_in_tlast) core_pending++;
      if (ev_out_hs) begin
        if (ev_out_last) begin core_pending--; core_beat = 0; end
        else core_beat++;
      end
      if (ev_src_hs) src_dat = src_dat + 32'h0101_0107;
    end
    bus.s_axis_tvalid = src_en;
    bus.s_axis_tdata  = src_dat;
    bus.i_fft_tready  = core_rdy;
    bus.i_out_tvalid  = out_en && (core_pending > 0);
    bus.i_out_tlast   = (core_beat == m_point - 1) || (core_beat == inj_at);
    bus.i_out_tready  = out_rdy;
  end

  // Compare on the falling edge, then advance the model across the next rising edge.
  always @(negedge aclk) begin
    if (!areset_n) model_reset();
    e_stream    = m_active && (m_fed < m_nframes);
    e_g         = (m_inflight < MAXI);
    e_mvalid    = e_stream && bus.s_axis_tvalid && e_g;
    e_sready    = e_stream && bus.i_fft_tready && e_g;
    e_tlast     = ((m_in_beats % m_point) == (m_point - 1));
    e_cfg_ready = !m_active && (m_inflight == 0);
    e_busy      = m_active || (m_inflight != 0);

    chk("m_fft_tvalid", bus.m_fft_tvalid, e_mvalid);
    chk("s_axis_tready", bus.s_axis_tready, e_sready);
    chk("m_fft_tlast", bus.m_fft_tlast, e_tlast);
    if (e_mvalid) chk("m_fft_tdata", bus.m_fft_tdata, bus.s_axis_tdata);
    chk("o_fft_point", bus.o_fft_point, m_point);
    chk("o_fft_inverse", bus.o_fft_inverse, m_inv);
    chk("o_cfg_ready", bus.o_cfg_ready, e_cfg_ready);
    chk("o_busy", bus.o_busy, e_busy);
    chk("o_err_cfg", bus.o_err_cfg, m_err_cfg);
    chk("o_err_len", bus.o_err_len, m_err_len);

    ev_src_hs   = areset_n && bus.s_axis_tvalid && bus.s_axis_tready;
    ev_in_tlast = areset_n && bus.m_fft_tvalid && bus.i_fft_tready && bus.m_fft_tlast;
    ev_out_hs   = areset_n && bus.i_out_tvalid && bus.i_out_tready;
    ev_out_last = ev_out_hs && bus.i_out_tlast;
    if (ev_in_tlast) begin
      if (tl_count == 0) tl_first = acc_beats;
      tl_lastidx = acc_beats;
      tl_count++;
    end
    if (ev_src_hs) acc_beats++;
    if (ev_in_tlast && ev_out_last) simul_cnt++;

    if (areset_n) begin
      x_in_hs   = e_mvalid && bus.i_fft_tready;
      x_in_fin  = x_in_hs && e_tlast;
      x_out_hs  = bus.i_out_tvalid && bus.i_out_tready;
      x_out_end = x_out_hs && (bus.i_out_tlast || (m_out_beats == m_point - 1));
      x_bad     = x_out_hs && ((bus.i_out_tlast != (m_out_beats == m_point - 1)) ||
                               (bus.i_out_tlast && m_inflight == 0));
      x_cfg_hs  = bus.i_cfg_valid && e_cfg_ready;
      x_legal   = (bus.i_cfg_point >= 16) && (bus.i_cfg_point <= 1024) &&
                  ($countones(bus.i_cfg_point) == 1);

      m_out_beats = x_out_end ? 0 : (x_out_hs ? m_out_beats + 1 : m_out_beats);
      m_err_cfg   = x_cfg_hs && !x_legal;
      if (x_cfg_hs && x_legal) begin
        m_point    = int'(bus.i_cfg_point);
        m_inv      = bus.i_cfg_inverse;
        m_nframes  = (bus.i_cfg_frames == 0) ? 256 : int'(bus.i_cfg_frames);
        m_fed      = 0;
        m_in_beats = 0;
        m_active   = 1;
        m_err_len  = 0;
      end else if (m_active && m_fed == m_nframes && m_inflight == 0) begin
        m_active = 0;
      end
      if (x_in_hs) m_in_beats++;
      if (x_in_fin) m_fed++;
      m_inflight = m_inflight + (x_in_fin ? 1 : 0) - ((x_out_end && m_inflight > 0) ? 1 : 0);
      if (x_bad) m_err_len = 1;
    end
  end

  task automatic reset_counters();
    acc_beats = 0; tl_count = 0; tl_first = -1; tl_lastidx = -1;
  endtask

  task automatic cfg_offer(input int p, input bit inv, input int f);
    @(posedge aclk); #1;
    bus.i_cfg_valid   = 1'b1;
    bus.i_cfg_point   = 11'(p);
    bus.i_cfg_inverse = inv;
    bus.i_cfg_frames  = 8'(f);
  endtask

  task automatic cfg_wait(input string name);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 2000) begin
      @(negedge aclk);
      n++;
      hit = bus.o_cfg_ready && bus.i_cfg_valid;
    end
    chk({name, "_cfg_accept"}, hit, 1);
    @(posedge aclk); #1;
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic do_cfg(input string name, input int p, input bit inv, input int f);
    cfg_offer(p, inv, f);
    cfg_wait(name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (bus.o_busy && n < budget);
    chk({name, "_idle"}, bus.o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_cfg_valid = 0; bus.i_cfg_point = 0; bus.i_cfg_inverse = 0; bus.i_cfg_frames = 0;
    bus.s_axis_tdata = 0; bus.s_axis_tvalid = 0; bus.i_fft_tready = 0;
    bus.i_out_tvalid = 0; bus.i_out_tready = 0; bus.i_out_tlast = 0;
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(negedge aclk);
    chk("rst_fft_point", bus.o_fft_point, 1024);
    chk("rst_cfg_ready", bus.o_cfg_ready, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_s_tready", bus.s_axis_tready, 0);

    // Two 64-point frames, free-running source and output
    src_en = 1; core_rdy = 1; out_en = 1; out_rdy = 1;
    reset_counters();
    do_cfg("t1", 64, 0, 2);
    @(negedge aclk);
    chk("t1_point_after_accept", bus.o_fft_point, 64);
    wait_idle("t1", 2000);
    chk("t1_beats", acc_beats, 128);
    chk("t1_tlast_count", tl_count, 2);
    chk("t1_tlast_first", tl_first, 63);
    chk("t1_tlast_second", tl_lastidx, 127);

    // Output blocked: source must stop after MAX_INFLIGHT frames
    out_rdy = 0;
    reset_counters();
    do_cfg("t2", 64, 1, 4);
    repeat (300) @(negedge aclk);
    chk("t2_stall_beats", acc_beats, 128);
    chk("t2_stall_tready", bus.s_axis_tready, 0);
    cfg_offer(32, 0, 1);
    repeat (3) @(negedge aclk);
    chk("t2_cfg_ready_inflight", bus.o_cfg_ready, 0);
    @(posedge aclk); #1 out_rdy = 1;
    cfg_wait("t2b");
    chk("t2_total_beats", acc_beats, 256);
    chk("t2_simul_tlast_seen", simul_cnt != 0, 1);
    reset_counters();
    wait_idle("t2b", 500);
    chk("t2b_beats", acc_beats, 32);

    // Early output tlast at beat 30 of a 64-point frame
    inj_at = 30;
    reset_counters();
    do_cfg("t4", 64, 0, 1);
    wait_idle("t4", 1000);
    chk("t4_err_len", bus.o_err_len, 1);
    inj_at = -1;

    // Illegal point is rejected without touching the config
    do_cfg("t3", 100, 1, 1);
    @(negedge aclk);
    chk("t3_err_cfg_pulse", bus.o_err_cfg, 1);
    chk("t3_point_kept", bus.o_fft_point, 64);
    chk("t3_idle", bus.o_busy, 0);
    @(negedge aclk);
    chk("t3_err_cfg_clear", bus.o_err_cfg, 0);
    chk("t3_err_len_held", bus.o_err_len, 1);

    // Legal job clears the length error; frames=0 runs 256 frames
    reset_counters();
    do_cfg("t5", 16, 0, 0);
    @(negedge aclk);
    chk("t5_err_len_cleared", bus.o_err_len, 0);
    wait_idle("t5", 12000);
    chk("t5_beats", acc_beats, 4096);

    // Asynchronous reset mid-frame, then a clean job
    reset_counters();
    do_cfg("t6", 128, 1, 2);
    repeat (50) @(negedge aclk);
    @(posedge aclk); #1 areset_n = 1'b0;
    #1;
    chk("t6_async_tvalid", bus.m_fft_tvalid, 0);
    chk("t6_async_tready", bus.s_axis_tready, 0);
    chk("t6_async_point", bus.o_fft_point, 1024);
    chk("t6_async_inverse", bus.o_fft_inverse, 0);
    chk("t6_async_busy", bus.o_busy, 0);
    chk("t6_async_cfg_ready", bus.o_cfg_ready, 1);
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    reset_counters();
    do_cfg("t7", 16, 0, 3);
    wait_idle("t7", 1000);
    chk("t7_beats", acc_beats, 48);
    chk("t7_tlast_count", tl_count, 3);

    repeat (5) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
